cla_pipe_adder: RTL and testbench
=================================

# cla_pipe_adder

Parametrised, pipelined carry-lookahead adder/subtractor with valid/ready handshakes on both sides.
- Operand width is split into fixed-size lookahead groups; each pipeline stage resolves one group and registers the inter-group carry, so throughput is one operation per clock at any width.
- Sits in arithmetic datapaths where a single-cycle wide adder would miss timing.
- Adds signed-overflow detection and an add/subtract mode.

## Interface
- `WIDTH`, default 32: operand and result width. Must be a multiple of `GROUP_W`; otherwise elaboration fails.
- `GROUP_W`, default 8: bits resolved per pipeline stage by one lookahead group.
- `STAGES`, derived, `WIDTH/GROUP_W`: pipeline depth.
- `clk` in 1: clock; all state changes on the rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `in_valid` in 1: input operation present.
- `in_ready` out 1: block accepts this cycle.
- `a` in WIDTH: operand A.
- `b` in WIDTH: operand B.
- `ci` in 1: carry-in. Ignored when `sub`=1.
- `sub` in 1: 0 computes a+b+ci; 1 computes a−b, as a+~b+1.
- `out_valid` out 1: result present.
- `out_ready` in 1: downstream accepts.
- `sum` out WIDTH: result, modulo 2^WIDTH.
- `co` out 1: carry out of the MSB. For subtract, 1 means no borrow (a ≥ b unsigned).
- `ovf` out 1: signed overflow, defined as carry into MSB XOR carry out of MSB.

## Operation
- Transfer occurs on `in_valid && in_ready` at input and `out_valid && out_ready` at output.
- Input stage forms `b_eff = sub ? ~b : b` and `c_eff = sub ? 1 : ci`.
- Stage k (0..STAGES−1) holds: valid bit, remaining operand bits, sum bits 0..(k+1)·GROUP_W−1, and the carry out of group k.
- Stage k computes group k from its operand slice and the carry-in registered by stage k−1 (stage 0 uses `c_eff`).
  - Per bit: G=a&b, P=a^b; group carries by lookahead; sum = P ^ carry.
- The final stage additionally captures carry into the MSB for `ovf`. It drives `sum`, `co`, `ovf`, `out_valid` directly from registers.
- Flow control is per stage: stage k loads when it is empty or stage k+1 loads/drains this cycle.
  - `in_ready` = !valid[0] || stage 0 advances.
  - Ready is a combinational chain from `out_ready`; no bubbles are required when all stages are full and `out_ready`=1.
- No state machine beyond the per-stage valid bits. Results leave strictly in acceptance order.

## Timing
- Reset (asynchronous assert, synchronous-safe deassert by system) clears all state:
  - `out_valid`=0, `sum`=0, `co`=0, `ovf`=0.
  - All stage valids 0.
  - `in_ready`=1 from the first cycle after reset releases.
- Latency: an operation accepted at edge t appears with `out_valid`=1 after edge t+STAGES−1. With the defaults that is 4 cycles, counting the capture edge as cycle 1.
- Throughput: 1 op/cycle sustained when `out_ready`=1.
- Stall: with `out_ready`=0 and the pipe full, `in_ready`=0 and all registers hold. `sum`/`co`/`ovf` must not change while `out_valid`=1 and not accepted.
- Simultaneous accept and drain in the same cycle, with the pipe full, is legal and lossless.
- Reset mid-operation discards every in-flight result; nothing is emitted after reset for pre-reset inputs.
- Inputs are sampled only on accept; `a`/`b`/`sub`/`ci` may change freely when not accepted.
- `GROUP_W`=`WIDTH` gives STAGES=1: a single registered stage with latency 1.

## Structure
- Package `cla_pkg` holds:
  - `cla_gp_t`, a struct of group generate and propagate.
  - An elaboration-time check function for `WIDTH % GROUP_W == 0`.
- Sub-module `cla_group`: purely combinational GROUP_W-bit lookahead group.
  - Inputs: a, b, cin.
  - Outputs: sum, cout, carry into top bit.
  - Instantiated once per stage inside a generate loop.
- Top contains the stage registers, valid/ready chain and operand skew registers.

## Test plan
- Add wrap: a=0xFFFFFFFF, b=0, ci=1, sub=0 → sum=0x00000000, co=1, ovf=0, out_valid 4 cycles after accept.
- Signed overflow: a=0x7FFFFFFF, b=0x00000001, ci=0 → sum=0x80000000, co=0, ovf=1.
- Subtract with borrow: a=5, b=7, sub=1, ci=1 (ignored) → sum=0xFFFFFFFE, co=0, ovf=0. Then a=7, b=5 → sum=2, co=1.
- Back-to-back throughput: 100 random ops with in_valid=1 and out_ready=1 every cycle.
  - in_ready stays 1 throughout.
  - Results match the model in order.
  - One result per cycle after the 4-cycle fill.
- Backpressure: fill the pipe, hold out_ready=0 for 10 cycles.
  - in_ready=0 once 4 are held; outputs stable.
  - Release: 4 results drain in order with no loss or duplication.
- Reset mid-flight: assert rst_n=0 with 3 ops in flight.
  - out_valid, sum, co, ovf are 0 immediately.
  - No stale result appears after release.
  - Repeat the first three scenarios with WIDTH=16, GROUP_W=4 and with GROUP_W=WIDTH.

Source files
------------

// File: rtl/cla_pkg.sv
// Shared types and helpers for the pipelined carry-lookahead adder.
package cla_pkg;

    // Generate/propagate pair describing a span of bits.
    typedef struct packed {
        logic g;
        logic p;
    } cla_gp_t;

    // Elaboration-time legality check on the width split.
    function automatic bit width_ok(int width, int group_w);
        return (group_w > 0) && (width >= group_w) && ((width % group_w) == 0);
    endfunction

    // Merge a higher span (hi) onto a lower span (lo) to give the combined span.
    function automatic cla_gp_t gp_combine(cla_gp_t hi, cla_gp_t lo);
        cla_gp_t r;
        r.g = hi.g | (hi.p & lo.g);
        r.p = hi.p & lo.p;
        return r;
    endfunction

endpackage

// File: rtl/cla_group.sv
// Purely combinational GROUP_W-bit carry-lookahead group.
module cla_group
    import cla_pkg::*;
#(
    parameter int GROUP_W = 8
) (
    input  logic [GROUP_W-1:0] a,
    input  logic [GROUP_W-1:0] b,
    input  logic               cin,
    output logic [GROUP_W-1:0] sum,
    output logic               cout,
    output logic               cmsb
);

    logic [GROUP_W-1:0] p;
    logic [GROUP_W:0]   c;

    assign p = a ^ b;

    // Every carry comes from the prefix G/P of bits 0..i applied to cin.
    always_comb begin
        cla_gp_t pre;
        cla_gp_t bit_gp;
        pre    = '{g: 1'b0, p: 1'b1};
        bit_gp = '{g: 1'b0, p: 1'b0};
        c      = '0;
        c[0]   = cin;
        for (int i = 0; i < GROUP_W; i++) begin
            bit_gp.g = a[i] & b[i];
            bit_gp.p = p[i];
            pre      = gp_combine(bit_gp, pre);
            c[i+1]   = pre.g | (pre.p & cin);
        end
    end

    assign sum  = p ^ c[GROUP_W-1:0];
    assign cout = c[GROUP_W];
    assign cmsb = c[GROUP_W-1];

endmodule

// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder/subtractor: one lookahead group per stage,
// inter-group carry registered, valid/ready flow control per stage.
module cla_pipe_adder
    import cla_pkg::*;
#(
    parameter  int WIDTH   = 32,
    parameter  int GROUP_W = 8,
    localparam int STAGES  = WIDTH / GROUP_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             co,
    output logic             ovf
);

    if (!width_ok(WIDTH, GROUP_W)) begin : g_bad_width
        $error("cla_pipe_adder: WIDTH (%0d) must be a positive multiple of GROUP_W (%0d)",
               WIDTH, GROUP_W);
    end

    logic [WIDTH-1:0]  b_eff;
    logic              c_eff;
    logic [STAGES-1:0] vld_q;
    logic [STAGES-1:0] vld_d;
    logic [STAGES-1:0] vin;
    logic [STAGES-1:0] ld;

    // Subtract is a + ~b + 1; carry-in is forced so ci is ignored.
    assign b_eff = sub ? ~b : b;
    assign c_eff = sub | ci;

    // Ready ripples back from out_ready: a stage loads if empty or its successor loads.
    always_comb begin
        logic nxt;
        nxt   = out_ready;
        ld    = '0;
        vin   = '0;
        vld_d = vld_q;
        for (int k = STAGES - 1; k >= 0; k--) begin
            ld[k] = !vld_q[k] || nxt;
            nxt   = ld[k];
        end
        vin[0] = in_valid;
        for (int k = 1; k < STAGES; k++) begin
            vin[k] = vld_q[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            if (ld[k]) vld_d[k] = vin[k];
        end
    end

    // Per-stage occupancy bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) vld_q <= '0;
        else        vld_q <= vld_d;
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int SRC_W = WIDTH - k * GROUP_W;
        localparam int SUM_W = (k + 1) * GROUP_W;

        logic [SRC_W-1:0]   src_a;
        logic [SRC_W-1:0]   src_b;
        logic               src_c;
        logic [SUM_W-1:0]   sum_d;
        logic [SUM_W-1:0]   sum_q;
        logic [GROUP_W-1:0] g_sum;
        logic               g_cout;
        logic               g_cmsb;
        logic               cout_q;
        logic               load_en;

        if (k == 0) begin : g_src
            assign src_a = a;
            assign src_b = b_eff;
            assign src_c = c_eff;
            assign sum_d = g_sum;
        end else begin : g_src
            assign src_a = g_stage[k-1].g_op.opa_q;
            assign src_b = g_stage[k-1].g_op.opb_q;
            assign src_c = g_stage[k-1].cout_q;
            assign sum_d = {g_sum, g_stage[k-1].sum_q};
        end

        // Data only moves when a valid operation enters the stage.
        assign load_en = ld[k] & vin[k];

        cla_group #(.GROUP_W(GROUP_W)) u_group (
            .a    (src_a[GROUP_W-1:0]),
            .b    (src_b[GROUP_W-1:0]),
            .cin  (src_c),
            .sum  (g_sum),
            .cout (g_cout),
            .cmsb (g_cmsb)
        );

        // Accumulated low sum bits and the carry out of this group.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sum_q  <= '0;
                cout_q <= 1'b0;
            end else if (load_en) begin
                sum_q  <= sum_d;
                cout_q <= g_cout;
            end
        end

        if (k < STAGES - 1) begin : g_op
            logic [SRC_W-GROUP_W-1:0] opa_q;
            logic [SRC_W-GROUP_W-1:0] opb_q;
            logic                     cmsb_unused;

            // Only the final group's carry into its top bit is the MSB carry.
            assign cmsb_unused = g_cmsb;

            // Skew registers: operand bits still waiting for later groups.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    opa_q <= '0;
                    opb_q <= '0;
                end else if (load_en) begin
                    opa_q <= src_a[SRC_W-1:GROUP_W];
                    opb_q <= src_b[SRC_W-1:GROUP_W];
                end
            end
        end else begin : g_last
            logic ovf_q;

            // Signed overflow: carry into MSB differs from carry out of MSB.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)       ovf_q <= 1'b0;
                else if (load_en) ovf_q <= g_cmsb ^ g_cout;
            end
        end
    end

    assign in_ready  = ld[0];
    assign out_valid = vld_q[STAGES-1];
    assign sum       = g_stage[STAGES-1].sum_q;
    assign co        = g_stage[STAGES-1].cout_q;
    assign ovf       = g_stage[STAGES-1].g_last.ovf_q;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Scoreboard bench for cla_pipe_adder: three configurations (32/8, 16/4, 32/32)
// share stimulus; only the 32/8 instance sees output backpressure.
module tb_cla_pipe_adder;

    typedef struct {
        logic [31:0] sum;
        logic        co;
        logic        ovf;
        int          acc;
        bit          chk;
    } exp_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        ci;
        logic        sub;
        logic [31:0] s32;
        logic        co32;
        logic        ov32;
        logic [31:0] s16;
        logic        co16;
        logic        ov16;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] a_s, b_s;
    logic        ci_s, sub_s, vld_s, ordy1, vld_g;
    logic        rdy1, rdy2, rdy3, ov1, ov2, ov3;
    logic [31:0] s1, s3;
    logic [15:0] s2;
    logic        co1, co2, co3, of1, of2, of3;
    bit          chk_rdy, bp_hold;
    int          n_cmp = 0, n_bad = 0, cyc = 0;
    exp_t        q1[$], q2[$], q3[$];
    vec_t        vt[7];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Secondary instances only accept when the main one does, keeping queues aligned.
    assign vld_g = vld_s & rdy1;

    cla_pipe_adder u_d32 (
        .clk(clk), .rst_n(rst_n), .in_valid(vld_s), .in_ready(rdy1),
        .a(a_s), .b(b_s), .ci(ci_s), .sub(sub_s),
        .out_valid(ov1), .out_ready(ordy1), .sum(s1), .co(co1), .ovf(of1));

    cla_pipe_adder #(.WIDTH(16), .GROUP_W(4)) u_d16 (
        .clk(clk), .rst_n(rst_n), .in_valid(vld_g), .in_ready(rdy2),
        .a(a_s[15:0]), .b(b_s[15:0]), .ci(ci_s), .sub(sub_s),
        .out_valid(ov2), .out_ready(1'b1), .sum(s2), .co(co2), .ovf(of2));

    cla_pipe_adder #(.WIDTH(32), .GROUP_W(32)) u_d1 (
        .clk(clk), .rst_n(rst_n), .in_valid(vld_g), .in_ready(rdy3),
        .a(a_s), .b(b_s), .ci(ci_s), .sub(sub_s),
        .out_valid(ov3), .out_ready(1'b1), .sum(s3), .co(co3), .ovf(of3));

    function automatic vec_t mkv(logic [31:0] a, logic [31:0] b, logic ci, logic sub,
                                 logic [31:0] s32, logic co32, logic ov32,
                                 logic [31:0] s16, logic co16, logic ov16);
        vec_t v;
        v.a = a; v.b = b; v.ci = ci; v.sub = sub;
        v.s32 = s32; v.co32 = co32; v.ov32 = ov32;
        v.s16 = s16; v.co16 = co16; v.ov16 = ov16;
        return v;
    endfunction

    // Reference: wide integer add, overflow from operand/result sign relation.
    function automatic exp_t model(int w, logic [31:0] a, logic [31:0] b, logic ci, logic sub);
        logic [32:0] mask, av, bv, tot;
        exp_t e;
        mask  = (33'd1 << w) - 33'd1;
        av    = {1'b0, a} & mask;
        bv    = (sub ? ~{1'b0, b} : {1'b0, b}) & mask;
        tot   = av + bv + {32'd0, (sub ? 1'b1 : ci)};
        e.sum = tot[31:0] & mask[31:0];
        e.co  = tot[w];
        e.ovf = (av[w-1] == bv[w-1]) && (tot[w-1] != av[w-1]);
        e.acc = 0;
        e.chk = 1'b1;
        return e;
    endfunction

    function automatic vec_t rand_vec();
        vec_t v;
        exp_t e;
        v.a = $urandom; v.b = $urandom;
        v.ci = 1'($urandom_range(0, 1)); v.sub = 1'($urandom_range(0, 1));
        e = model(32, v.a, v.b, v.ci, v.sub);
        v.s32 = e.sum; v.co32 = e.co; v.ov32 = e.ovf;
        e = model(16, v.a, v.b, v.ci, v.sub);
        v.s16 = e.sum; v.co16 = e.co; v.ov16 = e.ovf;
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h required %h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    task automatic score(input string nm, input exp_t e, input logic [31:0] s,
                         input logic c, input logic o, input int lat);
        check({nm, "_sum"}, s, e.sum);
        check({nm, "_co"}, 32'(c), 32'(e.co));
        check({nm, "_ovf"}, 32'(o), 32'(e.ovf));
        if (e.chk) check({nm, "_latency"}, 32'(cyc - e.acc), 32'(lat));
    endtask

    task automatic unexpected(input string nm, input logic [31:0] s);
        n_cmp++;
        n_bad++;
        $display("FAIL %s_unexpected: got output sum=%h, required no output", nm, s);
    endtask

    // Monitor: reset values, ready behaviour, stall stability, ordered scoreboard pops.
    initial begin
        exp_t        e;
        bit          held;
        logic [31:0] h_sum;
        logic        h_co, h_ovf;
        held = 1'b0; h_sum = '0; h_co = 1'b0; h_ovf = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                q1.delete(); q2.delete(); q3.delete();
                held = 1'b0;
                check("rst_out_valid32", 32'(ov1), 32'd0);
                check("rst_sum32", s1, 32'd0);
                check("rst_co32", 32'(co1), 32'd0);
                check("rst_ovf32", 32'(of1), 32'd0);
                check("rst_out_valid16", 32'(ov2), 32'd0);
                check("rst_out_valid1", 32'(ov3), 32'd0);
                check("rst_sum1", s3, 32'd0);
            end else begin
                if (chk_rdy) check("in_ready_stream", 32'(rdy1), 32'd1);
                if (bp_hold) begin
                    check("in_ready_full", 32'(rdy1), 32'd0);
                    check("out_valid_full", 32'(ov1), 32'd1);
                end
                if (ov1 && !ordy1) begin
                    if (held) begin
                        check("stall_sum", s1, h_sum);
                        check("stall_co", 32'(co1), 32'(h_co));
                        check("stall_ovf", 32'(of1), 32'(h_ovf));
                    end
                    held = 1'b1; h_sum = s1; h_co = co1; h_ovf = of1;
                end else begin
                    held = 1'b0;
                end
                if (ov1 && ordy1) begin
                    if (q1.size() == 0) unexpected("d32", s1);
                    else begin e = q1.pop_front(); score("d32", e, s1, co1, of1, 3); end
                end
                if (ov2) begin
                    if (q2.size() == 0) unexpected("d16", 32'(s2));
                    else begin e = q2.pop_front(); score("d16", e, 32'(s2), co2, of2, 3); end
                end
                if (ov3) begin
                    if (q3.size() == 0) unexpected("d1", s3);
                    else begin e = q3.pop_front(); score("d1", e, s3, co3, of3, 0); end
                end
            end
        end
    end

    // Called at the negedge before the accepting edge.
    task automatic push(input vec_t v);
        exp_t e;
        e.sum = v.s32; e.co = v.co32; e.ovf = v.ov32; e.acc = cyc + 1; e.chk = ordy1;
        q1.push_back(e);
        e.chk = 1'b1;
        q3.push_back(e);
        e.sum = v.s16; e.co = v.co16; e.ovf = v.ov16;
        q2.push_back(e);
    endtask

    task automatic present(input vec_t v);
        @(posedge clk); #1;
        a_s = v.a; b_s = v.b; ci_s = v.ci; sub_s = v.sub; vld_s = 1'b1;
    endtask

    task automatic issue(input vec_t v);
        present(v);
        for (int w = 0; ; w++) begin
            @(negedge clk);
            if (rdy1) break;
            if (w > 50) begin
                $display("FAIL issue_timeout: in_ready stayed 0, required 1 within 50 cycles");
                $fatal(1);
            end
        end
        push(v);
    endtask

    task automatic idle();
        @(posedge clk); #1;
        vld_s = 1'b0;
        a_s = $urandom; b_s = $urandom;
    endtask

    task automatic drain();
        for (int w = 0; ; w++) begin
            @(negedge clk);
            if (q1.size() == 0 && q2.size() == 0 && q3.size() == 0) break;
            if (w > 200) begin
                $display("FAIL drain_timeout: %0d results outstanding, required 0", q1.size());
                $fatal(1);
            end
        end
    endtask

    initial begin
        vec_t v;
        rst_n = 1'b1; a_s = '0; b_s = '0; ci_s = 1'b0; sub_s = 1'b0; vld_s = 1'b0;
        ordy1 = 1'b1; chk_rdy = 1'b0; bp_hold = 1'b0;
        //            a             b             ci    sub   sum32         co    ovf   sum16        co    ovf
        vt[0] = mkv(32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0, 32'h0000, 1'b1, 1'b0);
        vt[1] = mkv(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 32'h0000, 1'b1, 1'b0);
        vt[2] = mkv(32'h00000005, 32'h00000007, 1'b1, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 32'hFFFE, 1'b0, 1'b0);
        vt[3] = mkv(32'h00000007, 32'h00000005, 1'b0, 1'b1, 32'h00000002, 1'b1, 1'b0, 32'h0002, 1'b1, 1'b0);
        vt[4] = mkv(32'h00007FFF, 32'h00000001, 1'b0, 1'b0, 32'h00008000, 1'b0, 1'b0, 32'h8000, 1'b0, 1'b1);
        vt[5] = mkv(32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 32'hFFFF, 1'b0, 1'b0);
        vt[6] = mkv(32'h0000FFFF, 32'h0000FFFF, 1'b1, 1'b0, 32'h0001FFFF, 1'b0, 1'b0, 32'hFFFF, 1'b1, 1'b0);

        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1 chk_rdy = 1'b1;
        @(posedge clk); #1 chk_rdy = 1'b0;

        // Directed vectors, back to back.
        for (int i = 0; i < 7; i++) issue(vt[i]);
        idle();
        drain();

        // Sustained throughput: 100 random operations, one per cycle.
        @(posedge clk); #1 chk_rdy = 1'b1;
        for (int i = 0; i < 100; i++) issue(rand_vec());
        idle();
        chk_rdy = 1'b0;
        drain();

        // Backpressure: fill the 32/8 pipe, hold it for 10 cycles, then release.
        @(posedge clk); #1 ordy1 = 1'b0;
        for (int i = 0; i < 4; i++) issue(rand_vec());
        v = rand_vec();
        present(v);
        bp_hold = 1'b1;
        repeat (10) @(negedge clk);
        @(posedge clk); #1;
        bp_hold = 1'b0;
        ordy1 = 1'b1;
        @(negedge clk);
        check("in_ready_release", 32'(rdy1), 32'd1);
        if (rdy1) push(v);
        idle();
        drain();

        // Reset with three operations in flight; nothing may emerge afterwards.
        for (int i = 0; i < 3; i++) issue(rand_vec());
        @(posedge clk); #1;
        vld_s = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (10) @(posedge clk);

        // Pipe is usable again after the mid-flight reset.
        for (int i = 0; i < 7; i++) issue(vt[i]);
        idle();
        drain();
        repeat (3) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
